// File: rtl/titan_wb_arbiter.sv
// Round-robin arbiter merging titan_core's instruction and data Wishbone masters
// onto one classic single-beat bus, with a per-transaction timeout that returns err.
module titan_wb_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] iwbm_addr_i,
   input  logic        iwbm_cyc_i,
   input  logic        iwbm_stb_i,
   output logic [31:0] iwbm_dat_o,
   output logic        iwbm_ack_o,
   output logic        iwbm_err_o,
   input  logic [31:0] dwbm_addr_i,
   input  logic [31:0] dwbm_dat_i,
   input  logic [3:0]  dwbm_sel_i,
   input  logic        dwbm_we_i,
   input  logic        dwbm_cyc_i,
   input  logic        dwbm_stb_i,
   output logic [31:0] dwbm_dat_o,
   output logic        dwbm_ack_o,
   output logic        dwbm_err_o,
   output logic [31:0] wbm_addr_o,
   output logic [31:0] wbm_dat_o,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_we_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i
);

   typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

   localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_EN ? (TIMEOUT_CYCLES - 1) : 0);

   state_t           state, state_nx;
   logic             last_d, last_d_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   logic i_req, d_req, g_cyc, tmo_hit, resp_ack, resp_err;

   assign i_req = iwbm_cyc_i & iwbm_stb_i;
   assign d_req = dwbm_cyc_i & dwbm_stb_i;

   assign iwbm_dat_o = wbm_dat_i;
   assign dwbm_dat_o = wbm_dat_i;

   // Responses are only honoured while the granted master still holds cyc, so an
   // aborted cycle never reports ack/err. err wins over ack, and a real response
   // in the last timeout cycle suppresses the forced error.
   assign g_cyc    = (state == IGNT) ? iwbm_cyc_i :
                     (state == DGNT) ? dwbm_cyc_i : 1'b0;
   assign tmo_hit  = TMO_EN && (cnt == TMO_LAST);
   assign resp_err = g_cyc & (wbm_err_i | (tmo_hit & ~wbm_ack_i));
   assign resp_ack = g_cyc & wbm_ack_i & ~wbm_err_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         last_d <= 1'b1;
         cnt    <= '0;
      end else begin
         state  <= state_nx;
         last_d <= last_d_nx;
         cnt    <= cnt_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      last_d_nx  = last_d;
      cnt_nx     = cnt;
      wbm_addr_o = '0;
      wbm_dat_o  = '0;
      wbm_sel_o  = '0;
      wbm_we_o   = 1'b0;
      wbm_cyc_o  = 1'b0;
      wbm_stb_o  = 1'b0;
      iwbm_ack_o = 1'b0;
      iwbm_err_o = 1'b0;
      dwbm_ack_o = 1'b0;
      dwbm_err_o = 1'b0;

      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (i_req && (!d_req || last_d)) begin
               state_nx  = IGNT;
               last_d_nx = 1'b0;
            end else if (d_req) begin
               state_nx  = DGNT;
               last_d_nx = 1'b1;
            end
         end
         IGNT: begin
            wbm_addr_o = iwbm_addr_i;
            wbm_sel_o  = 4'hF;
            wbm_cyc_o  = iwbm_cyc_i;
            wbm_stb_o  = iwbm_stb_i;
            iwbm_ack_o = resp_ack;
            iwbm_err_o = resp_err;
         end
         DGNT: begin
            wbm_addr_o = dwbm_addr_i;
            wbm_dat_o  = dwbm_dat_i;
            wbm_sel_o  = dwbm_sel_i;
            wbm_we_o   = dwbm_we_i;
            wbm_cyc_o  = dwbm_cyc_i;
            wbm_stb_o  = dwbm_stb_i;
            dwbm_ack_o = resp_ack;
            dwbm_err_o = resp_err;
         end
         default: state_nx = IDLE;
      endcase

      if (state == IGNT || state == DGNT) begin
         if (!g_cyc || resp_ack || resp_err) begin
            state_nx = IDLE;
         end else begin
            cnt_nx = cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_titan_wb_arbiter.sv
// Bench for titan_wb_arbiter: table of single transactions checked through an
// expected-response queue, plus hand sequences for round-robin, timeout, abort, reset.
module tb_titan_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [31:0] iwbm_addr_i, iwbm_dat_o;
   logic        iwbm_cyc_i, iwbm_stb_i, iwbm_ack_o, iwbm_err_o;
   logic [31:0] dwbm_addr_i, dwbm_dat_i, dwbm_dat_o;
   logic [3:0]  dwbm_sel_i;
   logic        dwbm_we_i, dwbm_cyc_i, dwbm_stb_i, dwbm_ack_o, dwbm_err_o;
   logic [31:0] wbm_addr_o, wbm_dat_o, wbm_dat_i;
   logic [3:0]  wbm_sel_o;
   logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   titan_wb_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .iwbm_addr_i(iwbm_addr_i), .iwbm_cyc_i(iwbm_cyc_i), .iwbm_stb_i(iwbm_stb_i),
      .iwbm_dat_o(iwbm_dat_o), .iwbm_ack_o(iwbm_ack_o), .iwbm_err_o(iwbm_err_o),
      .dwbm_addr_i(dwbm_addr_i), .dwbm_dat_i(dwbm_dat_i), .dwbm_sel_i(dwbm_sel_i),
      .dwbm_we_i(dwbm_we_i), .dwbm_cyc_i(dwbm_cyc_i), .dwbm_stb_i(dwbm_stb_i),
      .dwbm_dat_o(dwbm_dat_o), .dwbm_ack_o(dwbm_ack_o), .dwbm_err_o(dwbm_err_o),
      .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
      .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
   );

   // resp: 0 ack, 1 err, 2 ack+err together, 3 slave silent (timeout)
   typedef struct {
      bit          is_d;
      logic [31:0] addr;
      logic [31:0] wdat;
      logic [3:0]  sel;
      bit          we;
      int          wait_cyc;
      int          resp;
      logic [31:0] rdat;
   } vec_t;

   typedef struct {
      bit          ack;
      bit          err;
      logic [31:0] dat;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic clear_masters();
      iwbm_addr_i = '0; iwbm_cyc_i = 1'b0; iwbm_stb_i = 1'b0;
      dwbm_addr_i = '0; dwbm_dat_i = '0; dwbm_sel_i = '0; dwbm_we_i = 1'b0;
      dwbm_cyc_i = 1'b0; dwbm_stb_i = 1'b0;
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      exp_t e;
      bit   done;
      logic m_ack, m_err, o_ack, o_err;
      logic [31:0] m_dat;
      @(posedge clk); #1;
      if (v.is_d) begin
         dwbm_addr_i = v.addr; dwbm_dat_i = v.wdat; dwbm_sel_i = v.sel;
         dwbm_we_i = v.we; dwbm_cyc_i = 1'b1; dwbm_stb_i = 1'b1;
      end else begin
         iwbm_addr_i = v.addr; iwbm_cyc_i = 1'b1; iwbm_stb_i = 1'b1;
      end
      e.ack = (v.resp == 0);
      e.err = (v.resp != 0);
      e.dat = v.rdat;
      e.cyc = (v.resp == 3) ? 4 : v.wait_cyc + 1;
      sb.push_back(e);
      @(negedge clk);
      chk($sformatf("v%0d_arb_idle", idx), wbm_cyc_o, 0);
      done = 0;
      for (int g = 1; g <= 8 && !done; g++) begin
         @(posedge clk); #1;
         if (v.resp == 3 || g == v.wait_cyc + 1) begin
            wbm_ack_i = (v.resp == 0 || v.resp == 2) && v.resp != 3;
            wbm_err_i = (v.resp == 1 || v.resp == 2) && v.resp != 3;
            wbm_dat_i = v.rdat;
         end else begin
            wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
            wbm_dat_i = 32'hBAD0_0000 | g;
         end
         @(negedge clk);
         if (g == 1) begin
            chk($sformatf("v%0d_cyc", idx), wbm_cyc_o, 1);
            chk($sformatf("v%0d_stb", idx), wbm_stb_o, 1);
            chk($sformatf("v%0d_addr", idx), wbm_addr_o, v.addr);
            chk($sformatf("v%0d_wdat", idx), wbm_dat_o, v.is_d ? v.wdat : 32'h0);
            chk($sformatf("v%0d_sel", idx), wbm_sel_o, v.is_d ? v.sel : 4'hF);
            chk($sformatf("v%0d_we", idx), wbm_we_o, v.is_d ? v.we : 1'b0);
         end
         m_ack = v.is_d ? dwbm_ack_o : iwbm_ack_o;
         m_err = v.is_d ? dwbm_err_o : iwbm_err_o;
         m_dat = v.is_d ? dwbm_dat_o : iwbm_dat_o;
         o_ack = v.is_d ? iwbm_ack_o : dwbm_ack_o;
         o_err = v.is_d ? iwbm_err_o : dwbm_err_o;
         if (m_ack || m_err || o_ack || o_err) begin
            done = 1;
            if (sb.size() == 0) begin
               checks++; failures++;
               $display("FAIL v%0d_unexpected_resp actual=response expected=none", idx);
            end else begin
               e = sb.pop_front();
               chk($sformatf("v%0d_ack", idx), m_ack, e.ack);
               chk($sformatf("v%0d_err", idx), m_err, e.err);
               chk($sformatf("v%0d_rdat", idx), m_dat, e.dat);
               chk($sformatf("v%0d_resp_cycle", idx), g, e.cyc);
               chk($sformatf("v%0d_cyc_held", idx), wbm_cyc_o, 1);
               chk($sformatf("v%0d_other_ack", idx), o_ack, 0);
               chk($sformatf("v%0d_other_err", idx), o_err, 0);
            end
         end
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL v%0d_no_response actual=none expected=response", idx);
      end
      @(posedge clk); #1;
      clear_masters();
      @(negedge clk);
      chk($sformatf("v%0d_idle_after", idx), wbm_cyc_o, 0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0, 1, 0, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011, 1'b1, 0, 0, 32'h0};
      vecs[2] = '{1'b1, 32'h0000_3000, 32'h0, 4'hF, 1'b0, 1, 1, 32'h5555_AAAA};
      vecs[3] = '{1'b0, 32'h0000_0200, 32'h0, 4'h0, 1'b0, 0, 3, 32'h0BAD_0BAD};
      vecs[4] = '{1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'b1100, 1'b1, 3, 0, 32'h0};
      vecs[5] = '{1'b0, 32'h0000_0500, 32'h0, 4'h0, 1'b0, 3, 1, 32'h7777_0000};
      vecs[6] = '{1'b1, 32'h0000_0600, 32'h0, 4'hF, 1'b0, 0, 2, 32'h0606_0606};
      vecs[7] = '{1'b0, 32'h0000_0700, 32'h0, 4'h0, 1'b0, 0, 0, 32'h0};

      clear_masters();
      wbm_dat_i = 32'hA5A5_A5A5;
      rst_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cyc", wbm_cyc_o, 0);
      chk("rst_stb", wbm_stb_o, 0);
      chk("rst_addr", wbm_addr_o, 0);
      chk("rst_sel", wbm_sel_o, 0);
      chk("rst_iack", iwbm_ack_o, 0);
      chk("rst_derr", dwbm_err_o, 0);
      chk("rst_idat", iwbm_dat_o, 32'hA5A5_A5A5);
      chk("rst_ddat", dwbm_dat_o, 32'hA5A5_A5A5);
      @(posedge clk); #1;
      rst_i = 1'b0;

      // Round-robin: simultaneous I/D after reset, I keeps requesting back-to-back
      iwbm_addr_i = 32'h1000_0000; iwbm_cyc_i = 1'b1; iwbm_stb_i = 1'b1;
      dwbm_addr_i = 32'h2000_0000; dwbm_sel_i = 4'hF; dwbm_cyc_i = 1'b1; dwbm_stb_i = 1'b1;
      @(negedge clk); chk("rr_idle0", wbm_cyc_o, 0);
      @(posedge clk); #1; wbm_ack_i = 1'b1; wbm_dat_i = 32'h1111_1111;
      @(negedge clk);
      chk("rr_first_i", wbm_addr_o, 32'h1000_0000);
      chk("rr_first_iack", iwbm_ack_o, 1);
      chk("rr_first_dack", dwbm_ack_o, 0);
      @(posedge clk); #1; wbm_ack_i = 1'b0; iwbm_addr_i = 32'h1000_0004;
      @(negedge clk); chk("rr_gap", wbm_cyc_o, 0);
      @(posedge clk); #1; wbm_ack_i = 1'b1;
      @(negedge clk);
      chk("rr_then_d", wbm_addr_o, 32'h2000_0000);
      chk("rr_then_dack", dwbm_ack_o, 1);
      chk("rr_then_iack", iwbm_ack_o, 0);
      @(posedge clk); #1; wbm_ack_i = 1'b0; dwbm_cyc_i = 1'b0; dwbm_stb_i = 1'b0;
      @(negedge clk); chk("rr_gap2", wbm_cyc_o, 0);
      @(posedge clk); #1; wbm_ack_i = 1'b1;
      @(negedge clk);
      chk("rr_then_i", wbm_addr_o, 32'h1000_0004);
      chk("rr_then_i_ack", iwbm_ack_o, 1);
      @(posedge clk); #1; clear_masters();

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Timeout on I while D waits; D must be served after the forced error
      @(posedge clk); #1;
      iwbm_addr_i = 32'h0000_4000; iwbm_cyc_i = 1'b1; iwbm_stb_i = 1'b1;
      for (int g = 1; g <= 4; g++) begin
         @(posedge clk); #1;
         dwbm_addr_i = 32'h0000_4400; dwbm_sel_i = 4'hF; dwbm_cyc_i = 1'b1; dwbm_stb_i = 1'b1;
         @(negedge clk);
         chk($sformatf("tmo_ierr_g%0d", g), iwbm_err_o, (g == 4));
         chk($sformatf("tmo_cyc_g%0d", g), wbm_cyc_o, 1);
      end
      @(posedge clk); #1; iwbm_cyc_i = 1'b0; iwbm_stb_i = 1'b0;
      @(negedge clk); chk("tmo_idle", wbm_cyc_o, 0);
      @(posedge clk); #1; wbm_ack_i = 1'b1;
      @(negedge clk);
      chk("tmo_d_granted", wbm_addr_o, 32'h0000_4400);
      chk("tmo_d_ack", dwbm_ack_o, 1);
      @(posedge clk); #1; clear_masters();

      // Abort: I drops cyc in grant cycle 2 while slave acks; D pending behind it
      @(posedge clk); #1;
      iwbm_addr_i = 32'h0000_5000; iwbm_cyc_i = 1'b1; iwbm_stb_i = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); chk("abt_cyc1", wbm_cyc_o, 1);
      @(posedge clk); #1;
      iwbm_cyc_i = 1'b0; iwbm_stb_i = 1'b0; wbm_ack_i = 1'b1;
      dwbm_addr_i = 32'h0000_5500; dwbm_sel_i = 4'hF; dwbm_cyc_i = 1'b1; dwbm_stb_i = 1'b1;
      @(negedge clk);
      chk("abt_cyc_drop", wbm_cyc_o, 0);
      chk("abt_no_ack", iwbm_ack_o, 0);
      chk("abt_no_err", iwbm_err_o, 0);
      chk("abt_no_dack", dwbm_ack_o, 0);
      @(posedge clk); #1; wbm_ack_i = 1'b0;
      @(negedge clk); chk("abt_idle", wbm_cyc_o, 0);
      @(posedge clk); #1; wbm_ack_i = 1'b1;
      @(negedge clk); chk("abt_d_granted", wbm_addr_o, 32'h0000_5500);
      @(posedge clk); #1; clear_masters();

      // Reset mid-grant; afterwards I must win the tie again
      @(posedge clk); #1;
      iwbm_addr_i = 32'h0000_6000; iwbm_cyc_i = 1'b1; iwbm_stb_i = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); chk("rstm_granted", wbm_cyc_o, 1);
      @(posedge clk); #1;
      rst_i = 1'b1;
      dwbm_addr_i = 32'h0000_6600; dwbm_sel_i = 4'hF; dwbm_cyc_i = 1'b1; dwbm_stb_i = 1'b1;
      @(negedge clk); chk("rstm_pre_edge", wbm_cyc_o, 1);
      @(posedge clk); #1; rst_i = 1'b0; wbm_ack_i = 1'b1;
      @(negedge clk);
      chk("rstm_cyc", wbm_cyc_o, 0);
      chk("rstm_stb", wbm_stb_o, 0);
      chk("rstm_addr", wbm_addr_o, 0);
      chk("rstm_sel", wbm_sel_o, 0);
      chk("rstm_iack", iwbm_ack_o, 0);
      chk("rstm_dack", dwbm_ack_o, 0);
      @(posedge clk); #1; wbm_ack_i = 1'b0;
      @(negedge clk); chk("rstm_tie_i", wbm_addr_o, 32'h0000_6000);
      @(posedge clk); #1; clear_masters();
      @(posedge clk);

      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "bench time limit");
   end

endmodule
